idex_fwd_stage: RTL and testbench
=================================

Name: idex_fwd_stage

Overview:
- ID/EX pipeline register with operand forwarding and load-use hazard detection for the 16-bit five-stage core.
- Captures decoded operands and control from decode and drives the ALU's A, B and Op inputs.
- Also drives store data, forwarded from EX/MEM and MEM/WB results.
- Raises a stall to decode on a load-use hazard and inserts a bubble.

Parameters:
DATA_W, 16, datapath width
REG_AW, 3, register-index width (8 GPRs; r0 is an ordinary register, not hardwired)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  decode holds a valid instruction
id_rs_val  input  DATA_W  register-file read value, rs
id_rt_val  input  DATA_W  register-file read value, rt
id_rs  input  REG_AW  rs index
id_rt  input  REG_AW  rt index
id_rs_used  input  1  instruction reads rs
id_rt_used  input  1  instruction reads rt
id_imm  input  DATA_W  extended immediate
id_use_imm  input  1  ALU B takes immediate instead of rt
id_alu_op  input  4  ALU operation code
id_rd  input  REG_AW  destination index
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
exmem_rd  input  REG_AW  EX/MEM destination
exmem_reg_write  input  1  EX/MEM writes a register
exmem_mem_read  input  1  EX/MEM is a load (result not yet valid)
exmem_result  input  DATA_W  EX/MEM ALU result
memwb_rd  input  REG_AW  MEM/WB destination
memwb_reg_write  input  1  MEM/WB writes a register
memwb_result  input  DATA_W  MEM/WB writeback value
mem_stall  input  1  downstream memory stall; hold this stage
flush  input  1  branch/jump redirect; kill this stage's contents
alu_a  output  DATA_W  ALU A operand (forwarded rs)
alu_b  output  DATA_W  ALU B operand (immediate or forwarded rt)
alu_op  output  4  registered ALU op
st_data  output  DATA_W  forwarded rt for stores
ex_valid  output  1  stage holds a valid instruction
ex_rd  output  REG_AW  registered destination
ex_reg_write  output  1  registered write enable, gated by ex_valid
ex_mem_read  output  1  registered load flag, gated by ex_valid
id_stall  output  1  decode must hold its instruction this cycle

Behaviour:
- Reset (async, immediate):
  - All registered fields = 0, ex_valid = 0.
  - Outputs therefore: alu_op = 0, alu_a = alu_b = st_data = 0 (no forwarding match when invalid), id_stall = 0.
- Registered fields: rs_val, rt_val, rs, rt, rs_used, rt_used, imm, use_imm, alu_op, rd, reg_write, mem_read, valid.
- id_stall (combinational), asserted when:
  - ex_valid & ex_mem_read & ex_rd != 0-agnostic match, i.e. (id_rs_used & id_rs == ex_rd) | (id_rt_used & id_rt == ex_rd),
  - AND id_valid.
- Per-cycle update, in priority order:
  1. flush: valid <= 0; other fields don't-care.
  2. mem_stall: all registers hold.
  3. id_stall: bubble inserted. valid <= 0, reg_write <= 0, mem_read <= 0.
  4. Otherwise: load all fields from decode; valid <= id_valid.
- Gating: ex_reg_write and ex_mem_read are the registered flags ANDed with ex_valid.
- Forwarding select per operand, with X = rs or rt (combinational on registered index):
  - EXMEM if exmem_reg_write & !exmem_mem_read & exmem_rd == X.
  - Else MEMWB if memwb_reg_write & memwb_rd == X.
  - Else NONE (registered value).
  - EX/MEM has priority over MEM/WB.
  - Selection applies only when the corresponding *_used bit is set; otherwise use the registered value.
- Operand outputs:
  - alu_a = fwd(rs).
  - alu_b = use_imm ? imm : fwd(rt).
  - st_data = fwd(rt) always.
- Output latency:
  - Operand outputs: zero-cycle latency from the forwarding inputs.
  - Control outputs: one cycle from the decode inputs.
- Assertion (bench): ex_valid & exmem_mem_read & exmem_rd matches a used source never occurs; load-use stall guarantees it.
- Held data during mem_stall: forwarding continues to re-evaluate each cycle; upstream stages hold correspondingly.
- Simultaneous flush and id_stall: flush wins, and id_stall is still driven so decode holds. Redirect logic in decode discards its instruction independently.
- No arithmetic in this block; widths pass through unchanged.

Decomposition:
- Shared package: DATA_W, REG_AW, the ALU op-code constants (shared with the ALU), and forward-select encoding FWD_NONE = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
- One sub-module, fwd_sel: given a source index, used bit, registered value and both forwarding ports, returns the selected operand. Instantiated twice (rs, rt).

Test Plan:
1. Reset mid-operation: ex_valid = 1, alu_op = 4'b0001, then assert rst -> ex_valid = 0, alu_op = 0, id_stall = 0 immediately, without waiting for a clock edge.
2. EX/MEM forward: registered rs = 3, rs_val = 16'h0005; exmem_rd = 3, exmem_reg_write = 1, exmem_result = 16'h1234 -> alu_a = 16'h1234. Add memwb_rd = 3, memwb_result = 16'hBEEF -> alu_a remains 16'h1234.
3. MEM/WB forward with immediate: rt = 2, use_imm = 1, imm = 16'h00FF; memwb_rd = 2, memwb_result = 16'hAAAA -> alu_b = 16'h00FF, st_data = 16'hAAAA.
4. Load-use: stage holds a load with ex_rd = 4; decode presents id_rs = 4, id_rs_used = 1 -> id_stall = 1. Next cycle ex_valid = 0 and ex_reg_write = 0. On the following cycle the instruction loads normally.
5. mem_stall for 3 cycles while decode changes its inputs -> alu_op, ex_rd and ex_valid unchanged throughout; new values are captured on the first cycle after mem_stall drops.
6. flush together with mem_stall -> ex_valid = 0 on the next cycle. Flush together with id_stall -> ex_valid = 0 and id_stall = 1.

Source files
------------

// File: rtl/idex_fwd_stage_pkg.sv
// Shared definitions for the ID/EX forwarding stage: widths, ALU op codes,
// forward-select encoding and the registered-field layout.
package idex_fwd_stage_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int ALU_OP_W = 4;

    // Op codes shared with the ALU.
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h8;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'h9;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [DATA_W-1:0]   rs_val;
        logic [DATA_W-1:0]   rt_val;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
        logic                rs_used;
        logic                rt_used;
        logic [DATA_W-1:0]   imm;
        logic                use_imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_AW-1:0]   rd;
        logic                reg_write;
        logic                mem_read;
        logic                valid;
    } idex_regs_t;

    // A load in EX/MEM has no result yet, so it is never a forwarding source.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_AW-1:0] src,
        input logic              used,
        input logic [REG_AW-1:0] exmem_rd,
        input logic              exmem_reg_write,
        input logic              exmem_mem_read,
        input logic [REG_AW-1:0] memwb_rd,
        input logic              memwb_reg_write
    );
        if (!used)
            return FWD_NONE;
        if (exmem_reg_write && !exmem_mem_read && exmem_rd == src)
            return FWD_EXMEM;
        if (memwb_reg_write && memwb_rd == src)
            return FWD_MEMWB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/idex_fwd_stage_if.sv
// Signal bundle between decode, the forwarding sources and the ID/EX stage.
interface idex_fwd_stage_if;
    import idex_fwd_stage_pkg::*;

    // Handshake: decode offers an instruction with id_valid; it is accepted on
    // a rising edge only when id_stall is low, otherwise decode must hold it.
    logic                id_valid;
    logic [DATA_W-1:0]   id_rs_val;
    logic [DATA_W-1:0]   id_rt_val;
    logic [REG_AW-1:0]   id_rs;
    logic [REG_AW-1:0]   id_rt;
    logic                id_rs_used;
    logic                id_rt_used;
    logic [DATA_W-1:0]   id_imm;
    logic                id_use_imm;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic [REG_AW-1:0]   id_rd;
    logic                id_reg_write;
    logic                id_mem_read;
    logic [REG_AW-1:0]   exmem_rd;
    logic                exmem_reg_write;
    logic                exmem_mem_read;
    logic [DATA_W-1:0]   exmem_result;
    logic [REG_AW-1:0]   memwb_rd;
    logic                memwb_reg_write;
    logic [DATA_W-1:0]   memwb_result;
    logic                mem_stall;
    logic                flush;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   st_data;
    logic                ex_valid;
    logic [REG_AW-1:0]   ex_rd;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                id_stall;

    modport master (
        output id_valid, id_rs_val, id_rt_val, id_rs, id_rt, id_rs_used, id_rt_used,
               id_imm, id_use_imm, id_alu_op, id_rd, id_reg_write, id_mem_read,
               exmem_rd, exmem_reg_write, exmem_mem_read, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result, mem_stall, flush,
        input  alu_a, alu_b, alu_op, st_data, ex_valid, ex_rd, ex_reg_write,
               ex_mem_read, id_stall
    );

    modport slave (
        input  id_valid, id_rs_val, id_rt_val, id_rs, id_rt, id_rs_used, id_rt_used,
               id_imm, id_use_imm, id_alu_op, id_rd, id_reg_write, id_mem_read,
               exmem_rd, exmem_reg_write, exmem_mem_read, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result, mem_stall, flush,
        output alu_a, alu_b, alu_op, st_data, ex_valid, ex_rd, ex_reg_write,
               ex_mem_read, id_stall
    );

endinterface

// File: rtl/idex_fwd_stage_fwd_sel.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB beats
// the value captured from the register file.
module idex_fwd_stage_fwd_sel
    import idex_fwd_stage_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic [DATA_W-1:0] reg_val,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] operand
);

    fwd_sel_e sel;

    always_comb begin
        sel = fwd_pick(src, used, exmem_rd, exmem_reg_write, exmem_mem_read,
                       memwb_rd, memwb_reg_write);
        case (sel)
            FWD_EXMEM: operand = exmem_result;
            FWD_MEMWB: operand = memwb_result;
            default:   operand = reg_val;
        endcase
    end

endmodule

// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register for the 16-bit core: captures decode, forwards
// operands from EX/MEM and MEM/WB, and stalls decode on a load-use hazard.
module idex_fwd_stage
    import idex_fwd_stage_pkg::*;
(
    input logic        clk,
    input logic        rst,
    idex_fwd_stage_if.slave bus
);

    idex_regs_t        r;
    logic              id_stall;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // A load sitting here produces its data too late for a consumer in decode.
    always_comb begin
        id_stall = bus.id_valid && r.valid && r.mem_read &&
                   ((bus.id_rs_used && bus.id_rs == r.rd) ||
                    (bus.id_rt_used && bus.id_rt == r.rd));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (bus.flush) begin
            r.valid <= 1'b0;
        end else if (bus.mem_stall) begin
            r <= r;
        end else if (id_stall) begin
            r.valid     <= 1'b0;
            r.reg_write <= 1'b0;
            r.mem_read  <= 1'b0;
        end else begin
            r.rs_val    <= bus.id_rs_val;
            r.rt_val    <= bus.id_rt_val;
            r.rs        <= bus.id_rs;
            r.rt        <= bus.id_rt;
            r.rs_used   <= bus.id_rs_used;
            r.rt_used   <= bus.id_rt_used;
            r.imm       <= bus.id_imm;
            r.use_imm   <= bus.id_use_imm;
            r.alu_op    <= bus.id_alu_op;
            r.rd        <= bus.id_rd;
            r.reg_write <= bus.id_reg_write;
            r.mem_read  <= bus.id_mem_read;
            r.valid     <= bus.id_valid;
        end
    end

    idex_fwd_stage_fwd_sel u_fwd_rs (
        .src             (r.rs),
        .used            (r.rs_used),
        .reg_val         (r.rs_val),
        .exmem_rd        (bus.exmem_rd),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_mem_read  (bus.exmem_mem_read),
        .exmem_result    (bus.exmem_result),
        .memwb_rd        (bus.memwb_rd),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_result    (bus.memwb_result),
        .operand         (fwd_rs)
    );

    idex_fwd_stage_fwd_sel u_fwd_rt (
        .src             (r.rt),
        .used            (r.rt_used),
        .reg_val         (r.rt_val),
        .exmem_rd        (bus.exmem_rd),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_mem_read  (bus.exmem_mem_read),
        .exmem_result    (bus.exmem_result),
        .memwb_rd        (bus.memwb_rd),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_result    (bus.memwb_result),
        .operand         (fwd_rt)
    );

    assign bus.alu_a        = fwd_rs;
    assign bus.alu_b        = r.use_imm ? r.imm : fwd_rt;
    assign bus.st_data      = fwd_rt;
    assign bus.alu_op       = r.alu_op;
    assign bus.ex_valid     = r.valid;
    assign bus.ex_rd        = r.rd;
    assign bus.ex_reg_write = r.reg_write && r.valid;
    assign bus.ex_mem_read  = r.mem_read && r.valid;
    assign bus.id_stall     = id_stall;

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Directed bench for idex_fwd_stage: reset, forwarding priority, load-use
// stall, memory stall hold and flush behaviour.
module tb_idex_fwd_stage;
    import idex_fwd_stage_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    idex_fwd_stage_if bus ();

    idex_fwd_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_rs_val = '0; bus.id_rt_val = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_imm = '0; bus.id_use_imm = 0; bus.id_alu_op = '0; bus.id_rd = '0;
        bus.id_reg_write = 0; bus.id_mem_read = 0;
        bus.exmem_rd = '0; bus.exmem_reg_write = 0; bus.exmem_mem_read = 0;
        bus.exmem_result = '0; bus.memwb_rd = '0; bus.memwb_reg_write = 0;
        bus.memwb_result = '0; bus.mem_stall = 0; bus.flush = 0;
    endtask

    // A loaded value must never be consumed straight out of EX/MEM.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.exmem_mem_read &&
            ((dut.r.rs_used && bus.exmem_rd == dut.r.rs) ||
             (dut.r.rt_used && bus.exmem_rd == dut.r.rt))) begin
            failures++;
            $error("FAIL load_use_escape observed=1 expected=0");
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
        chk("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
        chk("rst_st_data", {16'd0, bus.st_data}, 32'd0);

        // 1. reset in the middle of operation clears without a clock edge
        bus.id_valid = 1; bus.id_alu_op = ALU_SUB; bus.id_rd = 3'd1; bus.id_reg_write = 1;
        tick();
        chk("pre_rst_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("pre_rst_alu_op", {28'd0, bus.alu_op}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("async_rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
        chk("async_rst_id_stall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        rst = 1'b0;

        // 2. EX/MEM forward and its priority over MEM/WB
        clear_inputs();
        bus.id_valid = 1; bus.id_rs = 3'd3; bus.id_rs_used = 1; bus.id_rs_val = 16'h0005;
        bus.id_alu_op = ALU_ADD;
        tick();
        chk("no_fwd_alu_a", {16'd0, bus.alu_a}, 32'h0005);
        bus.exmem_rd = 3'd3; bus.exmem_reg_write = 1; bus.exmem_result = 16'h1234;
        #1 chk("exmem_fwd_alu_a", {16'd0, bus.alu_a}, 32'h1234);
        bus.memwb_rd = 3'd3; bus.memwb_reg_write = 1; bus.memwb_result = 16'hBEEF;
        #1 chk("exmem_prio_alu_a", {16'd0, bus.alu_a}, 32'h1234);
        bus.exmem_reg_write = 0;
        #1 chk("memwb_fwd_alu_a", {16'd0, bus.alu_a}, 32'hBEEF);
        bus.exmem_rd = 3'd6; bus.exmem_reg_write = 1;
        #1 chk("exmem_other_rd_alu_a", {16'd0, bus.alu_a}, 32'hBEEF);

        // r0 is an ordinary register and is forwarded like any other
        clear_inputs();
        bus.id_valid = 1; bus.id_rs = 3'd0; bus.id_rs_used = 1; bus.id_rs_val = 16'h0101;
        tick();
        bus.exmem_rd = 3'd0; bus.exmem_reg_write = 1; bus.exmem_result = 16'h4242;
        #1 chk("r0_fwd_alu_a", {16'd0, bus.alu_a}, 32'h4242);

        // 3. MEM/WB forward on rt while B takes the immediate
        clear_inputs();
        bus.id_valid = 1; bus.id_rt = 3'd2; bus.id_rt_used = 1; bus.id_rt_val = 16'h0011;
        bus.id_use_imm = 1; bus.id_imm = 16'h00FF;
        tick();
        bus.memwb_rd = 3'd2; bus.memwb_reg_write = 1; bus.memwb_result = 16'hAAAA;
        #1;
        chk("imm_alu_b", {16'd0, bus.alu_b}, 32'h00FF);
        chk("memwb_st_data", {16'd0, bus.st_data}, 32'hAAAA);
        bus.id_rt_used = 0; bus.id_use_imm = 0;
        tick();
        chk("unused_rt_st_data", {16'd0, bus.st_data}, 32'h0011);
        chk("unused_rt_alu_b", {16'd0, bus.alu_b}, 32'h0011);

        // 4. load-use hazard: stall, bubble, then normal capture
        clear_inputs();
        bus.id_valid = 1; bus.id_rd = 3'd4; bus.id_reg_write = 1; bus.id_mem_read = 1;
        tick();
        chk("load_ex_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
        chk("load_ex_rd", {29'd0, bus.ex_rd}, 32'd4);
        clear_inputs();
        bus.id_rs = 3'd4; bus.id_rs_used = 1; bus.id_alu_op = ALU_OR;
        bus.id_rd = 3'd5; bus.id_reg_write = 1;
        #1 chk("stall_needs_id_valid", {31'd0, bus.id_stall}, 32'd0);
        bus.id_valid = 1; bus.id_rs_used = 0; bus.id_rt = 3'd4; bus.id_rt_used = 1;
        #1 chk("stall_rt_match", {31'd0, bus.id_stall}, 32'd1);
        bus.id_rt_used = 0;
        #1 chk("no_stall_unused", {31'd0, bus.id_stall}, 32'd0);
        bus.id_rt = 3'd0; bus.id_rs_used = 1;
        #1 chk("stall_rs_match", {31'd0, bus.id_stall}, 32'd1);
        tick();
        chk("bubble_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("bubble_ex_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("bubble_id_stall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        chk("after_bubble_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("after_bubble_alu_op", {28'd0, bus.alu_op}, {28'd0, ALU_OR});
        chk("after_bubble_ex_rd", {29'd0, bus.ex_rd}, 32'd5);

        // 5. mem_stall holds the stage while forwarding keeps tracking
        bus.mem_stall = 1;
        bus.id_alu_op = ALU_SRA; bus.id_rd = 3'd6; bus.id_rs_used = 0;
        bus.exmem_rd = 3'd4; bus.exmem_reg_write = 1; bus.exmem_result = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_alu_op", {28'd0, bus.alu_op}, {28'd0, ALU_OR});
            chk("hold_ex_rd", {29'd0, bus.ex_rd}, 32'd5);
            chk("hold_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        end
        chk("hold_fwd_alu_a", {16'd0, bus.alu_a}, 32'h7777);
        bus.mem_stall = 0;
        tick();
        chk("release_alu_op", {28'd0, bus.alu_op}, {28'd0, ALU_SRA});
        chk("release_ex_rd", {29'd0, bus.ex_rd}, 32'd6);

        // 6. flush beats mem_stall, and beats id_stall while stall stays visible
        bus.mem_stall = 1; bus.flush = 1;
        tick();
        chk("flush_mem_stall_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        clear_inputs();
        bus.id_valid = 1; bus.id_rd = 3'd2; bus.id_reg_write = 1; bus.id_mem_read = 1;
        tick();
        clear_inputs();
        bus.id_valid = 1; bus.id_rs = 3'd2; bus.id_rs_used = 1; bus.flush = 1;
        #1 chk("flush_id_stall", {31'd0, bus.id_stall}, 32'd1);
        tick();
        chk("flush_stall_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_ex_mem_read_gated", {31'd0, bus.ex_mem_read}, 32'd0);
        bus.flush = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
